// File: rtl/seg_display_pkg.sv
// Shared types and segment decode for the multi-channel 7-segment driver.
// Segments are active-low, bit order gfedcba.
package seg_display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    STORE
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  function automatic logic [6:0] seg7_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/multi_seg_display_tick_gen.sv
// Free-running prescaler for the display refresh.
// Emits a one-cycle tick every DIV clocks.
module tick_gen #(
  parameter int DIV = 1_000_000
) (
  input  logic clk,
  input  logic n_reset,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/multi_seg_display.sv
// Sequential multi-channel binary-to-BCD 7-segment driver (double-dabble).
// Optional: LEADING_ZERO_BLANK_EN blanks leading zero digits above units.
module multi_seg_display
  import seg_display_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 3,
  parameter int CHANNELS    = 2,
  parameter int SIGNED      = 1,
  parameter int REFRESH_DIV = 1_000_000
) (
  input  logic                             clk,
  input  logic                             n_reset,
  input  logic [CHANNELS*WIDTH-1:0]        values,
  input  logic                             force_upd,
  output logic [CHANNELS*(DIGITS+1)*7-1:0] hex,
  output logic                             busy
);

  localparam int HW = CHANNELS * (DIGITS + 1) * 7;
  localparam int BW = 4 * DIGITS;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int NW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (10 ** DIGITS < 2 ** WIDTH) begin : g_digits_chk
    $error("multi_seg_display: DIGITS too small for WIDTH");
  end

  logic [1:0]       rst_sync;
  logic             rst_n;
  logic             tick;
  logic             req;
  logic             pending;
  state_t           state;
  logic [CW-1:0]    chan;
  logic [NW-1:0]    bit_cnt;
  logic [WIDTH-1:0] mag;
  logic [BW-1:0]    bcd;
  logic [BW-1:0]    bcd_adj;
  logic             neg;
  logic [WIDTH-1:0] value_c;
  logic             value_neg;
  logic [HW-1:0]    hex_q;
  logic [6:0]       seg [DIGITS+1];

  // Reset asserts immediately, releases two clocks later
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rst_sync <= '0;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  tick_gen #(
    .DIV(REFRESH_DIV)
  ) u_tick (
    .clk    (clk),
    .n_reset(rst_n),
    .tick   (tick)
  );

  assign req       = tick | force_upd;
  assign value_c   = values[int'(chan)*WIDTH +: WIDTH];
  assign value_neg = (SIGNED != 0) && value_c[WIDTH-1];

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic lead;

  always_comb begin
    lead = 1'b1;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      if (d != 0 && lead && bcd[4*d +: 4] == 4'd0) begin
        seg[d] = SEG_BLANK;
      end else begin
        seg[d] = seg7_decode(bcd[4*d +: 4]);
      end
      lead = lead && (bcd[4*d +: 4] == 4'd0);
    end
    seg[DIGITS] = neg ? SEG_MINUS : SEG_BLANK;
  end
`else
  always_comb begin
    for (int d = 0; d < DIGITS; d++) begin
      seg[d] = seg7_decode(bcd[4*d +: 4]);
    end
    seg[DIGITS] = neg ? SEG_MINUS : SEG_BLANK;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
      state   <= IDLE;
      busy    <= 1'b0;
      chan    <= '0;
      bit_cnt <= '0;
      mag     <= '0;
      bcd     <= '0;
      neg     <= 1'b0;
      hex_q   <= {HW{1'b1}};
    end else begin
      if (state == IDLE && pending) begin
        pending <= 1'b0;
      end else if (req) begin
        pending <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (pending) begin
            chan  <= '0;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          neg     <= value_neg;
          mag     <= value_neg ? (~value_c + 1'b1) : value_c;
          bcd     <= '0;
          bit_cnt <= '0;
          state   <= SHIFT;
        end
        SHIFT: begin
          bcd     <= BW'({bcd_adj, mag[WIDTH-1]});
          mag     <= mag << 1;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == NW'(WIDTH - 1)) begin
            state <= STORE;
          end
        end
        STORE: begin
          for (int d = 0; d <= DIGITS; d++) begin
            hex_q[(int'(chan)*(DIGITS+1)+d)*7 +: 7] <= seg[d];
          end
          if (chan == CW'(CHANNELS - 1)) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            chan  <= chan + 1'b1;
            state <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign hex = hex_q;

endmodule

// File: tb/tb_multi_seg_display.sv
// Scoreboard bench for multi_seg_display: frames checked on busy fall.
// Leading-zero expectations follow LEADING_ZERO_BLANK_EN.
module tb_multi_seg_display;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] MN = 7'b0111111;
  localparam logic [6:0] BL = 7'b1111111;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        force_upd;
  logic        force_b;
  logic [15:0] values;
  logic [55:0] hex_a;
  logic [55:0] hex_b;
  logic        busy_a;
  logic        busy_b;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [55:0] hex;
    string       name;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  multi_seg_display #(
    .WIDTH(8), .DIGITS(3), .CHANNELS(2),
    .SIGNED(1), .REFRESH_DIV(50000)
  ) dut_a (
    .clk      (clk),
    .n_reset  (n_reset),
    .values   (values),
    .force_upd(force_upd),
    .hex      (hex_a),
    .busy     (busy_a)
  );

  multi_seg_display #(
    .WIDTH(8), .DIGITS(3), .CHANNELS(2),
    .SIGNED(0), .REFRESH_DIV(16)
  ) dut_b (
    .clk      (clk),
    .n_reset  (n_reset),
    .values   (values),
    .force_upd(force_b),
    .hex      (hex_b),
    .busy     (busy_b)
  );

  function automatic logic [27:0] ch(
    input logic [6:0] s, h, t, u
  );
    return {s, h, t, u};
  endfunction

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pop one expectation per completed frame
  logic prev_busy = 1'b0;
  int   blen      = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!n_reset) begin
      prev_busy = 1'b0;
      blen      = 0;
    end else begin
      if (busy_a) blen++;
      if (prev_busy && !busy_a) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_frame: got %h", hex_a);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_hex"}, 64'(hex_a), 64'(e.hex));
          chk({e.name, "_len"}, 64'(blen), 64'd20);
        end
        blen = 0;
      end
      prev_busy = busy_a;
    end
  end

  task automatic push(input string name, input logic [55:0] h);
    exp_t e;
    e.name = name;
    e.hex  = h;
    sb.push_back(e);
  endtask

  task automatic pulse;
    @(posedge clk);
    #1 force_upd = 1'b1;
    @(posedge clk);
    #1 force_upd = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while ((sb.size() != 0 || busy_a) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_done"}, 64'(k < 200), 64'd1);
  endtask

  task automatic wait_busy_a(input string name);
    int k = 0;
    while (!busy_a && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_start"}, 64'(k < 40), 64'd1);
  endtask

  task automatic wait_fall_b(input string name);
    int  k  = 0;
    logic pb = busy_b;
    logic done = 1'b0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
      if (pb && !busy_b) done = 1'b1;
      pb = busy_b;
    end
    chk({name, "_fall"}, 64'(done), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [55:0] e;
    int          k;
    int          cnt;

    n_reset   = 1'b0;
    force_upd = 1'b0;
    force_b   = 1'b0;
    values    = '0;
    repeat (3) @(posedge clk);
    #1 n_reset = 1'b1;

    // 1: idle after reset
    repeat (10) @(negedge clk);
    chk("t1_hex_a", 64'(hex_a), {8'h0, {56{1'b1}}});
    chk("t1_busy_a", 64'(busy_a), 64'd0);
    chk("t1_hex_b", 64'(hex_b), {8'h0, {56{1'b1}}});
    k = 0;
    while (!busy_b && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("t1_b_tick_start", 64'(k < 60), 64'd1);

    // 2/3: 123 and -128
    values = {8'h80, 8'd123};
    push("t2", {ch(MN, S1, S2, S8), ch(BL, S1, S2, S3)});
    pulse();
    wait_done("t2");

    // unsigned build shows 128, refreshes back to back
    wait_fall_b("t3b_1");
    wait_fall_b("t3b_2");
    chk("t3b_hex", 64'(hex_b),
        64'({ch(BL, S1, S2, S8), ch(BL, S1, S2, S3)}));
    @(negedge clk);
    chk("t3b_restart", 64'(busy_b), 64'd1);

    // 4: two requests during a frame -> one extra frame
    values = {8'hFB, 8'd5};
`ifdef LEADING_ZERO_BLANK_EN
    e = {ch(MN, BL, BL, S5), ch(BL, BL, BL, S5)};
`else
    e = {ch(MN, S0, S0, S5), ch(BL, S0, S0, S5)};
`endif
    push("t4a", e);
    push("t4b", e);
    pulse();
    wait_busy_a("t4");
    repeat (5) @(negedge clk);
    pulse();
    repeat (3) @(negedge clk);
    pulse();
    k = 0;
    while (busy_a && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("t4_first_end", 64'(k < 40), 64'd1);
    @(negedge clk);
    chk("t4_b2b", 64'(busy_a), 64'd1);
    wait_done("t4");
    cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (busy_a) cnt++;
    end
    chk("t4_no_extra", 64'(cnt), 64'd0);

    // 5: reset during 5th SHIFT of ch1
    values = {8'h00, 8'd127};
    pulse();
    wait_busy_a("t5");
    repeat (15) @(negedge clk);
    chk("t5_partial", 64'(hex_a), 64'({e[55:28], ch(BL, S1, S2, S7)}));
    n_reset = 1'b0;
    #1;
    chk("t5_rst_hex", 64'(hex_a), {8'h0, {56{1'b1}}});
    chk("t5_rst_busy", 64'(busy_a), 64'd0);
    repeat (3) @(posedge clk);
    #1 n_reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("t5_still_blank", 64'(hex_a), {8'h0, {56{1'b1}}});
`ifdef LEADING_ZERO_BLANK_EN
    push("t5", {ch(BL, BL, BL, S0), ch(BL, S1, S2, S7)});
`else
    push("t5", {ch(BL, S0, S0, S0), ch(BL, S1, S2, S7)});
`endif
    pulse();
    wait_done("t5");

    // 6: zero and two-digit value
    values = {8'd99, 8'd0};
`ifdef LEADING_ZERO_BLANK_EN
    push("t6", {ch(BL, BL, S9, S9), ch(BL, BL, BL, S0)});
`else
    push("t6", {ch(BL, S0, S9, S9), ch(BL, S0, S0, S0)});
`endif
    pulse();
    wait_done("t6");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
